// File: rtl/ros2_sub_msg_reader.sv
// rtl/ros2_sub_msg_reader.sv - subscriber message buffer with ownership handshake and byte-stream readout
module ros2_sub_msg_reader #(
    parameter int MAX_APP_DATA_LEN = 64,
    parameter int AWIDTH           = $clog2(MAX_APP_DATA_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] sub_app_data_addr,
    input  logic              sub_app_data_ce,
    input  logic              sub_app_data_we,
    input  logic [7:0]        sub_app_data_wdata,
    input  logic [7:0]        sub_app_data_len,
    input  logic [15:0]       sub_app_data_rep_id,
    input  logic              sub_app_data_recv,
    input  logic              sub_app_data_grant,
    output logic              sub_app_data_req,
    output logic              sub_app_data_rel,
    output logic [7:0]        m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [7:0]        m_len,
    output logic [15:0]       m_rep_id,
    output logic              busy,
    output logic [15:0]       overrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_REL
    } state_t;

    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_APP_DATA_LEN);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_mem [MAX_APP_DATA_LEN];
    logic        r_pending;
    logic [15:0] r_overrun_cnt;
    logic [7:0]  r_idx;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic [7:0]  r_len;
    logic [15:0] r_rep_id;
    logic [7:0]  w_clamp_len;
    logic        w_hs;

    assign w_clamp_len = (sub_app_data_len > LP_MAX_LEN) ? LP_MAX_LEN : sub_app_data_len;
    assign w_hs        = r_tvalid & m_tready;

    assign sub_app_data_req = (r_state == S_REQ);
    assign sub_app_data_rel = (r_state == S_REL);
    assign busy             = (r_state != S_IDLE);
    assign m_tdata          = r_tdata;
    assign m_tvalid         = r_tvalid;
    assign m_tlast          = r_tlast;
    assign m_len            = r_len;
    assign m_rep_id         = r_rep_id;
    assign overrun_cnt      = r_overrun_cnt;

    // The core owns write timing; writes land regardless of ownership state.
    always_ff @(posedge clk) begin
        if (sub_app_data_ce && sub_app_data_we) begin
            r_mem[sub_app_data_addr] <= sub_app_data_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (sub_app_data_recv || r_pending) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (sub_app_data_grant) begin
                    w_next = (w_clamp_len == 8'd0) ? S_REL : S_READ;
                end
            end
            S_READ: begin
                if (w_hs && r_tlast) begin
                    w_next = S_REL;
                end
            end
            S_REL: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Only one notification can wait behind the active transfer; further ones are counted as lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= 1'b0;
            r_overrun_cnt <= 16'd0;
        end else if (r_state == S_IDLE) begin
            r_pending <= 1'b0;
        end else if (sub_app_data_recv) begin
            if (!r_pending) begin
                r_pending <= 1'b1;
            end else if (r_overrun_cnt != 16'hFFFF) begin
                r_overrun_cnt <= r_overrun_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= 8'd0;
            r_tdata  <= 8'd0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_len    <= 8'd0;
            r_rep_id <= 16'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (sub_app_data_grant) begin
                        r_len    <= w_clamp_len;
                        r_rep_id <= sub_app_data_rep_id;
                        if (w_clamp_len != 8'd0) begin
                            r_tdata  <= r_mem[0];
                            r_tvalid <= 1'b1;
                            r_tlast  <= (w_clamp_len == 8'd1);
                            r_idx    <= 8'd1;
                        end
                    end
                end
                S_READ: begin
                    if (w_hs) begin
                        if (!r_tlast) begin
                            r_tdata <= r_mem[r_idx[AWIDTH-1:0]];
                            r_tlast <= (r_idx == r_len - 8'd1);
                            r_idx   <= r_idx + 8'd1;
                        end else begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ros2_sub_msg_reader.sv
// tb/tb_ros2_sub_msg_reader.sv - self-checking bench for ros2_sub_msg_reader
module tb_ros2_sub_msg_reader;

    localparam int MAXL = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  addr;
    logic        ce;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  len;
    logic [15:0] rep;
    logic        recv;
    logic        grant;
    logic        req;
    logic        rel;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [7:0]  o_len;
    logic [15:0] o_rep_id;
    logic        busy;
    logic [15:0] overrun_cnt;

    ros2_sub_msg_reader #(.MAX_APP_DATA_LEN(MAXL)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sub_app_data_addr   (addr),
        .sub_app_data_ce     (ce),
        .sub_app_data_we     (we),
        .sub_app_data_wdata  (wdata),
        .sub_app_data_len    (len),
        .sub_app_data_rep_id (rep),
        .sub_app_data_recv   (recv),
        .sub_app_data_grant  (grant),
        .sub_app_data_req    (req),
        .sub_app_data_rel    (rel),
        .m_tdata             (tdata),
        .m_tvalid            (tvalid),
        .m_tready            (tready),
        .m_tlast             (tlast),
        .m_len               (o_len),
        .m_rep_id            (o_rep_id),
        .busy                (busy),
        .overrun_cnt         (overrun_cnt)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         hs_cnt = 0;
    int         rel_cnt = 0;
    int         grants_served = 0;
    logic [7:0] last_byte = 8'd0;
    logic [7:0] tb_mem [MAXL];
    logic [7:0] exp_q [$];
    bit         last_q [$];
    bit         tr_stop = 1'b0;
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_last = 1'b0;
    logic [7:0] p_data = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: a granted message is the first min(len, MAXL) buffer bytes, tlast on the final one.
    task automatic push_exp(input int l);
        int n;
        n = (l > MAXL) ? MAXL : l;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(tb_mem[i]);
            last_q.push_back(i == n - 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                check("stall_valid", tvalid, 1);
                check("stall_data", tdata, p_data);
                check("stall_last", tlast, p_last);
            end
            if (tvalid && tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte", tdata);
                end else begin
                    check("stream_data", tdata, exp_q.pop_front());
                    check("stream_last", tlast, last_q.pop_front());
                    if (tlast) last_byte = tdata;
                end
            end
            if (rel) begin
                rel_cnt++;
                check("req_in_rel", req, 0);
            end
            p_valid = tvalid;
            p_ready = tready;
            p_data  = tdata;
            p_last  = tlast;
        end
    end

    task automatic write_byte(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        tb_mem[a] = d;
    endtask

    task automatic end_write();
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic write_hi();
        write_byte(6'd0, 8'h48);
        write_byte(6'd1, 8'h69);
        write_byte(6'd2, 8'h21);
        end_write();
    endtask

    task automatic start_msg(input logic [7:0] l, input logic [15:0] r);
        len = l;
        rep = r;
        push_exp(int'(l));
        @(posedge clk); #1; recv = 1'b1;
        @(posedge clk); #1; recv = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        @(negedge clk);
        while (!req && k < 50) begin @(negedge clk); k++; end
        check("req_seen", req, 1);
    endtask

    task automatic wait_rel();
        int k = 0;
        while (!rel && k < 300) begin @(negedge clk); k++; end
        check("rel_seen", rel, 1);
    endtask

    task automatic serve_grant(input int dly);
        wait_req();
        if (req) begin
            repeat (dly) @(posedge clk);
            @(posedge clk); #1; grant = 1'b1;
            wait_rel();
            @(posedge clk); #1; grant = 1'b0;
        end
        grants_served++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, req, 0);
        check({tag, "_rel"}, rel, 0);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_len"}, o_len, 0);
        check({tag, "_rep_id"}, o_rep_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int h0;
        int r0;
        int gs0;
        int k;
        rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        len = '0; rep = '0; recv = 1'b0; grant = 1'b0; tready = 1'b1;
        for (int i = 0; i < MAXL; i++) tb_mem[i] = 8'd0;
        #3;
        check_all_zero("reset");
        #19 rst_n = 1'b1;

        // Basic "Hi!" transfer with exact handshake timing
        write_hi();
        h0 = hs_cnt; r0 = rel_cnt;
        len = 8'd3; rep = 16'h1234;
        push_exp(3);
        @(posedge clk); #1; recv = 1'b1;
        @(negedge clk); check("req_before_recv_sampled", req, 0);
        @(posedge clk); #1; recv = 1'b0;
        @(negedge clk); check("req_rise", req, 1); check("busy_in_req", busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1; grant = 1'b1;
        @(negedge clk); check("tvalid_in_grant_cycle", tvalid, 0);
        @(negedge clk);
        check("first_tvalid", tvalid, 1);
        check("first_tdata", tdata, 8'h48);
        check("t1_m_len", o_len, 8'd3);
        check("t1_m_rep_id", o_rep_id, 16'h1234);
        wait_rel();
        @(posedge clk); #1; grant = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_busy_done", busy, 0);
        check("t1_hs_count", hs_cnt - h0, 3);
        check("t1_rel_count", rel_cnt - r0, 1);
        check("t1_last_byte", last_byte, 8'h21);
        check("t1_queue_drained", exp_q.size(), 0);

        // Back-pressure with tready pattern 1,0,0,1
        h0 = hs_cnt; r0 = rel_cnt;
        tr_stop = 1'b0;
        fork
            begin
                for (int c = 0; c < 400 && !tr_stop; c++) begin
                    @(posedge clk); #1;
                    if (!tr_stop) tready = (c % 4 == 0) || (c % 4 == 3);
                end
            end
        join_none
        start_msg(8'd3, 16'hBEEF);
        serve_grant(2);
        tr_stop = 1'b1;
        @(posedge clk); #1; tready = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_hs_count", hs_cnt - h0, 3);
        check("t2_rel_count", rel_cnt - r0, 1);
        check("t2_m_rep_id", o_rep_id, 16'hBEEF);
        check("t2_queue_drained", exp_q.size(), 0);

        // Zero-length message
        h0 = hs_cnt; r0 = rel_cnt;
        start_msg(8'd0, 16'h00AA);
        wait_req();
        @(posedge clk); #1; grant = 1'b1;
        @(negedge clk); check("t3_rel_in_grant_cycle", rel, 0);
        @(negedge clk);
        check("t3_rel_after_grant", rel, 1);
        check("t3_no_tvalid", tvalid, 0);
        check("t3_m_len", o_len, 8'd0);
        check("t3_m_rep_id", o_rep_id, 16'h00AA);
        @(posedge clk); #1; grant = 1'b0;
        @(negedge clk);
        check("t3_busy_done", busy, 0);
        check("t3_hs_count", hs_cnt - h0, 0);
        check("t3_rel_count", rel_cnt - r0, 1);

        // Over-length message clamps to the buffer depth
        for (int i = 0; i < MAXL; i++) write_byte(6'(i), 8'((i * 7 + 3) & 8'hFF));
        end_write();
        h0 = hs_cnt; r0 = rel_cnt;
        start_msg(8'd200, 16'h5A5A);
        serve_grant(1);
        repeat (2) @(negedge clk);
        check("t4_m_len_clamped", o_len, 8'd64);
        check("t4_hs_count", hs_cnt - h0, 64);
        check("t4_last_byte", last_byte, 8'hBC);
        check("t4_rel_count", rel_cnt - r0, 1);
        check("t4_busy_done", busy, 0);

        // Notifications during a stalled transfer: one queued, one dropped
        write_hi();
        @(posedge clk); #1; tready = 1'b0;
        len = 8'd3; rep = 16'h0F0F;
        push_exp(3);
        push_exp(3);
        h0 = hs_cnt; r0 = rel_cnt; gs0 = grants_served;
        fork
            serve_grant(0);
        join_none
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1; recv = (c == 0) || (c == 5) || (c == 6);
        end
        @(posedge clk); #1; recv = 1'b0;
        @(negedge clk);
        check("t5_overrun", overrun_cnt, 16'd1);
        check("t5_stalled_tvalid", tvalid, 1);
        check("t5_stalled_tdata", tdata, 8'h48);
        check("t5_busy", busy, 1);
        @(posedge clk); #1; tready = 1'b1;
        k = 0;
        while (grants_served == gs0 && k < 300) begin @(negedge clk); k++; end
        check("t5_first_done", grants_served - gs0, 1);
        serve_grant(0);
        repeat (2) @(negedge clk);
        check("t5_hs_count", hs_cnt - h0, 6);
        check("t5_rel_count", rel_cnt - r0, 2);
        check("t5_overrun_final", overrun_cnt, 16'd1);
        check("t5_busy_done", busy, 0);

        // Asynchronous reset in the middle of READ
        @(posedge clk); #1; tready = 1'b0;
        r0 = rel_cnt;
        start_msg(8'd3, 16'h7777);
        wait_req();
        @(posedge clk); #1; grant = 1'b1;
        @(posedge clk); #1; tready = 1'b1;
        @(posedge clk); #1; tready = 1'b0;
        check("t6_tdata_idx2", tdata, 8'h69);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        exp_q.delete();
        last_q.delete();
        grant = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1; tready = 1'b1;
        check("t6_no_rel", rel_cnt - r0, 0);
        h0 = hs_cnt; r0 = rel_cnt;
        start_msg(8'd3, 16'h4321);
        serve_grant(0);
        repeat (2) @(negedge clk);
        check("t6_fresh_hs_count", hs_cnt - h0, 3);
        check("t6_fresh_last_byte", last_byte, 8'h21);
        check("t6_fresh_rep_id", o_rep_id, 16'h4321);
        check("t6_fresh_rel_count", rel_cnt - r0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
